// File: rtl/e203_itcm_pkg.sv
// rtl/e203_itcm_pkg.sv - shared defaults and response entry type for the ITCM IFU responder
// Default build leaves E203_ITCM_HOLDUP_EN undefined.
package e203_itcm_pkg;

  localparam int ITCM_AW         = 16;
  localparam int ITCM_DW         = 64;
  localparam int ITCM_BYTES_DFLT = 65536;
  localparam int ITCM_WOFF       = $clog2(ITCM_DW / 8);

  typedef struct packed {
    logic               err;
    logic [ITCM_DW-1:0] rdata;
  } rsp_ent_t;

endpackage

// File: rtl/e203_itcm_ifu_slv_if.sv
// rtl/e203_itcm_ifu_slv_if.sv - ICB fetch command/response bundle between IFU and ITCM
interface e203_itcm_ifu_slv_if
  import e203_itcm_pkg::*;
#(
  parameter int AW = ITCM_AW,
  parameter int DW = ITCM_DW
);

  logic          icb_cmd_valid;
  logic          icb_cmd_ready;
  logic [AW-1:0] icb_cmd_addr;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready;
  logic          icb_rsp_err;
  logic [DW-1:0] icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

endinterface

// File: rtl/e203_itcm_rsp_fifo.sv
// rtl/e203_itcm_rsp_fifo.sv - 2-entry {err,rdata} response skid FIFO
module e203_itcm_rsp_fifo
  import e203_itcm_pkg::*;
#(
  parameter type ENT_T = rsp_ent_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  ENT_T       push_ent,
  input  logic       pop,
  output ENT_T       head,
  output logic [1:0] cnt
);

  ENT_T       mem_q [2];
  ENT_T       mem_d [2];
  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = push_ent;
      wptr_d        = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
    end
    // With cnt==2 a push+pop overwrites the slot being popped; head is read from mem_q first.
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head = mem_q[rptr_q];
  assign cnt  = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && cnt_q == 2'd0));

endmodule

// File: rtl/e203_itcm_ifu_slv.sv
// rtl/e203_itcm_ifu_slv.sv - ITCM-side ICB responder for instruction fetch with skid FIFO and holdup
// Optional holdup tracking is enabled by defining E203_ITCM_HOLDUP_EN.
module e203_itcm_ifu_slv
  import e203_itcm_pkg::*;
#(
  parameter int AW         = ITCM_AW,
  parameter int DW         = ITCM_DW,
  parameter int ITCM_BYTES = ITCM_BYTES_DFLT
) (
  input  logic                          clk,
  input  logic                          rst,
  e203_itcm_ifu_slv_if.slave            icb,
  input  logic                          ext_ram_req,
  input  logic                          itcm_nohold,
  output logic                          holdup,
  output logic                          ram_cs,
  output logic [AW-$clog2(DW/8)-1:0]    ram_addr,
  input  logic [DW-1:0]                 ram_dout
);

  localparam int WOFF = $clog2(DW / 8);

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } ent_t;

  logic       inflight_q, inflight_d;
  logic       inflight_err_q, inflight_err_d;
  logic [1:0] fifo_cnt;
  logic [1:0] occ;
  logic       fifo_nempty;
  logic       fifo_push, fifo_pop;
  logic       accept, in_range;
  ent_t       byp_ent, fifo_head, rsp_ent;

  assign in_range    = 33'(icb.icb_cmd_addr) < 33'(ITCM_BYTES);
  assign fifo_nempty = fifo_cnt != 2'd0;
  assign occ         = fifo_cnt + {1'b0, inflight_q};

  // occ never exceeds 2, so a FIFO pop is the only way a full pipe can take a new command.
  assign fifo_pop          = fifo_nempty & icb.icb_rsp_ready;
  assign icb.icb_cmd_ready = ~rst & ~ext_ram_req & ((occ < 2'd2) | fifo_pop);
  assign accept            = icb.icb_cmd_valid & icb.icb_cmd_ready;

  assign ram_cs   = accept & in_range;
  assign ram_addr = icb.icb_cmd_addr[AW-1:WOFF];

  always_comb begin
    inflight_d     = accept;
    inflight_err_d = accept & ~in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q     <= 1'b0;
      inflight_err_q <= 1'b0;
    end else begin
      inflight_q     <= inflight_d;
      inflight_err_q <= inflight_err_d;
    end
  end

  assign byp_ent.err   = inflight_err_q;
  assign byp_ent.rdata = inflight_err_q ? '0 : ram_dout;

  // SRAM data is only valid for one cycle, so it is captured unless it leaves via the bypass.
  assign fifo_push = inflight_q & (fifo_nempty | ~icb.icb_rsp_ready);

  e203_itcm_rsp_fifo #(.ENT_T(ent_t)) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_ent (byp_ent),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .cnt      (fifo_cnt)
  );

  assign rsp_ent           = fifo_nempty ? fifo_head : byp_ent;
  assign icb.icb_rsp_valid = ~rst & (fifo_nempty | inflight_q);
  assign icb.icb_rsp_err   = icb.icb_rsp_valid & rsp_ent.err;
  assign icb.icb_rsp_rdata = icb.icb_rsp_valid ? rsp_ent.rdata : '0;

  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    !(inflight_q && fifo_cnt == 2'd2));

`ifdef E203_ITCM_HOLDUP_EN
  logic                holdup_q, holdup_d;
  logic [AW-WOFF-1:0]  hold_waddr_q, hold_waddr_d;

  // Any other SRAM access or an err fetch means the array output no longer holds our word.
  always_comb begin
    holdup_d     = holdup_q;
    hold_waddr_d = hold_waddr_q;
    if (ext_ram_req || (accept && !in_range)) begin
      holdup_d = 1'b0;
    end else if (ram_cs) begin
      holdup_d     = 1'b1;
      hold_waddr_d = ram_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      holdup_q     <= 1'b0;
      hold_waddr_q <= '0;
    end else begin
      holdup_q     <= holdup_d;
      hold_waddr_q <= hold_waddr_d;
    end
  end

  assign holdup = holdup_q & ~ext_ram_req & ~itcm_nohold & ~rst;
`else
  logic unused_nohold;
  assign unused_nohold = itcm_nohold;
  assign holdup        = 1'b0;
`endif

endmodule

// File: tb/tb_e203_itcm_ifu_slv.sv
// tb/tb_e203_itcm_ifu_slv.sv - scoreboard bench for the ITCM IFU responder
module tb_e203_itcm_ifu_slv;

  localparam int AW    = 17;
  localparam int DW    = 64;
  localparam int BYTES = 65536;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ext_ram_req = 1'b0;
  logic          itcm_nohold = 1'b0;
  logic          holdup;
  logic          ram_cs;
  logic [AW-4:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;

  e203_itcm_ifu_slv_if #(.AW(AW), .DW(DW)) icb ();

  e203_itcm_ifu_slv #(.AW(AW), .DW(DW), .ITCM_BYTES(BYTES)) dut (
    .clk         (clk),
    .rst         (rst),
    .icb         (icb),
    .ext_ram_req (ext_ram_req),
    .itcm_nohold (itcm_nohold),
    .holdup      (holdup),
    .ram_cs      (ram_cs),
    .ram_addr    (ram_addr),
    .ram_dout    (ram_dout)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [8192];
  logic [DW:0]   exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            outstanding = 0;
  bit            hflag = 0;
  bit            rand_mode = 0;
  bit            stall_prev = 0;
  logic [DW:0]   stall_data;

  // Behavioural SRAM: one-cycle read, other requester scrambles the output.
  always @(posedge clk) begin
    if (ram_cs) ram_dout <= mem[ram_addr[12:0]];
    else if (ext_ram_req) ram_dout <= {$urandom, $urandom};
  end

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW:0] model_rsp(input logic [AW-1:0] a);
    if (32'(a) >= BYTES) return {1'b1, 64'h0};
    return {1'b0, mem[a[15:3]]};
  endfunction

  // Monitor: inputs are stable at negedge; compare, then advance the model to the next cycle.
  always @(negedge clk) begin
    bit acc, dlv;
    logic [DW:0] e;
    if (rst) begin
      chk("rst_cmd_ready", {64'h0, icb.icb_cmd_ready}, 65'd0);
      chk("rst_rsp_valid", {64'h0, icb.icb_rsp_valid}, 65'd0);
      chk("rst_ram_cs", {64'h0, ram_cs}, 65'd0);
      chk("rst_holdup", {64'h0, holdup}, 65'd0);
      outstanding = 0;
      exp_q.delete();
      hflag = 0;
      stall_prev = 0;
    end else begin
      chk("cmd_ready", {64'h0, icb.icb_cmd_ready},
          {64'h0, !ext_ram_req && (outstanding < 2 || icb.icb_rsp_ready)});
      chk("rsp_valid", {64'h0, icb.icb_rsp_valid}, {64'h0, outstanding > 0});
`ifdef E203_ITCM_HOLDUP_EN
      chk("holdup", {64'h0, holdup}, {64'h0, hflag && !ext_ram_req && !itcm_nohold});
`else
      chk("holdup_off", {64'h0, holdup}, 65'd0);
`endif
      acc = icb.icb_cmd_valid && icb.icb_cmd_ready;
      dlv = icb.icb_rsp_valid && icb.icb_rsp_ready;
      chk("ram_cs", {64'h0, ram_cs}, {64'h0, acc && 32'(icb.icb_cmd_addr) < BYTES});
      if (ram_cs) chk("ram_addr", {51'h0, ram_addr}, {51'h0, icb.icb_cmd_addr[AW-1:3]});
      if (stall_prev && icb.icb_rsp_valid)
        chk("rsp_stable", {icb.icb_rsp_err, icb.icb_rsp_rdata}, stall_data);
      stall_prev = icb.icb_rsp_valid && !icb.icb_rsp_ready;
      stall_data = {icb.icb_rsp_err, icb.icb_rsp_rdata};
      if (dlv) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 65'd1, 65'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_err", {64'h0, icb.icb_rsp_err}, {64'h0, e[DW]});
          chk("rsp_rdata", {1'b0, icb.icb_rsp_rdata}, {1'b0, e[DW-1:0]});
        end
      end
      outstanding = outstanding + int'(acc) - int'(dlv);
      if (ext_ram_req) hflag = 0;
      else if (acc) hflag = 32'(icb.icb_cmd_addr) < BYTES;
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      icb.icb_rsp_ready = ($urandom % 4) != 0;
      ext_ram_req       = ($urandom % 8) == 0;
      itcm_nohold       = ($urandom % 8) == 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    bit acc = 0;
    int n = 0;
    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_addr  = a;
    exp_q.push_back(model_rsp(a));
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = icb.icb_cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    icb.icb_cmd_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 65'd0, 65'd1);
      void'(exp_q.pop_back());
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    for (int i = 0; i < 8192; i++) mem[i] = {$urandom, $urandom};
    icb.icb_cmd_valid = 1'b0;
    icb.icb_cmd_addr  = '0;
    icb.icb_rsp_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    fetch(17'h00000);
    fetch(17'h00008);
    fetch(17'h00010);
    idle(3);

    icb.icb_rsp_ready = 1'b0;
    fork
      begin
        fetch(17'h00100);
        fetch(17'h00108);
        fetch(17'h00110);
      end
      begin
        idle(4);
        icb.icb_rsp_ready = 1'b1;
      end
    join
    idle(3);

    fetch(17'h10000);
    fetch(17'h1fff8);
    idle(2);

    ext_ram_req = 1'b1;
    fork
      fetch(17'h00200);
      begin
        idle(2);
        ext_ram_req = 1'b0;
      end
    join
    idle(2);

    fetch(17'h00020);
    idle(2);
    ext_ram_req = 1'b1;
    idle(1);
    ext_ram_req = 1'b0;
    fetch(17'h00020);
    itcm_nohold = 1'b1;
    idle(2);
    itcm_nohold = 1'b0;
    idle(1);
    fetch(17'h10020);
    idle(2);

    icb.icb_rsp_ready = 1'b0;
    fetch(17'h00040);
    fetch(17'h00048);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    icb.icb_rsp_ready = 1'b1;
    idle(3);

    rand_mode = 1;
    for (int k = 0; k < 300; k++) begin
      if (($urandom % 10) == 0) a = 17'(32'h10000 + $urandom_range(0, 65535));
      else a = 17'($urandom_range(0, 65535));
      fetch(a);
      idle($urandom_range(0, 2));
    end
    rand_mode = 0;
    idle(1);
    icb.icb_rsp_ready = 1'b1;
    ext_ram_req = 1'b0;
    itcm_nohold = 1'b0;
    idle(10);
    chk("drain_empty", 65'(exp_q.size()), 65'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
